// File: rtl/crypto_itf_pkg.sv
// Shared encodings for the crypto host interface: host commands, FSM states
// and the bit layout of the status word returned at address 0.
package crypto_itf_pkg;

  localparam logic [3:0] CMD_IDLE     = 4'b0000;
  localparam logic [3:0] CMD_WRITE    = 4'b0001;
  localparam logic [3:0] CMD_START    = 4'b0010;
  localparam logic [3:0] CMD_SOFT_RST = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_e;

  localparam int ST_END  = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_ILL  = 3;

endpackage

// File: rtl/itf_watchdog.sv
// Cycle counter that flags when the core has been busy for TIMEOUT cycles.
// A TIMEOUT of 0 removes the counter and never expires.
module itf_watchdog #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_wd;
    assign unused_wd = &{1'b0, clk, rst_n, clr_i, en_i};
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
        cnt_q <= '0;
      end else if (en_i && cnt_q != LIMIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign expired_o = en_i && (cnt_q == LIMIT);
  end

endmodule

// File: rtl/crypto_host_itf.sv
// Host register interface for one crypto core: mode/input bank writes,
// start/done handshake with watchdog, result capture and registered reads.
module crypto_host_itf
  import crypto_itf_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int N_IN    = 32,
  parameter int N_OUT   = 8,
  parameter int MODE_W  = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             control,
  input  logic [ADDR_W-1:0]      address,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   end_op,
  output logic                   busy,
  output logic                   error,
  output logic                   core_rst_n,
  output logic                   core_start,
  output logic [MODE_W-1:0]      core_mode,
  output logic [N_IN*WIDTH-1:0]  core_in,
  input  logic                   core_done,
  input  logic                   core_err,
  input  logic [N_OUT*WIDTH-1:0] core_out
);

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q;
  logic [WIDTH-1:0]  bank_q [N_IN];
  logic [WIDTH-1:0]  res_q  [N_OUT];
  logic [WIDTH-1:0]  data_out_q, rdata;
  logic              end_op_q, error_q, ill_q, core_rst_n_q;
  logic              clear, is_write, is_start, launch, finish, fail, capture;
  logic              wd_expired;

  // Hard reset and the SOFT_RST command share one clearing path.
  assign clear    = !rst_n || (control == CMD_SOFT_RST);
  assign is_write = (control == CMD_WRITE);
  assign is_start = (control == CMD_START);

  always_ff @(posedge clk) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (is_start) state_d = S_START;
      S_START: state_d = S_BUSY;
      S_BUSY:  if (core_err || core_done || wd_expired) state_d = S_DONE;
      S_DONE:  state_d = is_start ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    core_start = 1'b0;
    case (state_q)
      S_START: begin
        busy       = 1'b1;
        core_start = 1'b1;
      end
      S_BUSY:  busy = 1'b1;
      default: ;
    endcase
  end

  // DONE is not busy, so a START right after completion is accepted there too.
  assign launch  = is_start && (state_q == S_IDLE || state_q == S_DONE);
  assign finish  = (state_q == S_BUSY) && (core_err || core_done || wd_expired);
  assign fail    = (state_q == S_BUSY) && (core_err || (!core_done && wd_expired));
  assign capture = (state_q == S_BUSY) && core_done && !core_err;

  itf_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == S_START),
    .en_i      (state_q == S_BUSY),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (clear || launch) begin
      end_op_q <= 1'b0;
      error_q  <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      if (finish)                      end_op_q <= 1'b1;
      if (fail)                        error_q  <= 1'b1;
      if (busy && (is_write || is_start)) ill_q <= 1'b1;
    end
  end

  // NOTE: the bank is reset like any register because core_in must read 0 after reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      mode_q <= '0;
      for (int k = 0; k < N_IN; k++) bank_q[k] <= '0;
    end else if (is_write && !busy) begin
      if (address == '0) mode_q <= data_in[MODE_W-1:0];
      for (int k = 0; k < N_IN; k++) begin
        if (address == ADDR_W'(k + 1)) bank_q[k] <= data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int k = 0; k < N_OUT; k++) res_q[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < N_OUT; k++) res_q[k] <= core_out[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    rdata = '0;
    if (address == '0) begin
      rdata[ST_END]  = end_op_q;
      rdata[ST_BUSY] = busy;
      rdata[ST_ERR]  = error_q;
      rdata[ST_ILL]  = ill_q;
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (address == ADDR_W'(k + 1)) rdata = res_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      data_out_q   <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      data_out_q   <= rdata;
      core_rst_n_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_core_in
    assign core_in[k*WIDTH +: WIDTH] = bank_q[k];
  end

  assign data_out   = data_out_q;
  assign end_op     = end_op_q;
  assign error      = error_q;
  assign core_rst_n = core_rst_n_q;
  assign core_mode  = mode_q;

endmodule

// File: tb/tb_crypto_host_itf.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_crypto_host_itf;
  import crypto_itf_pkg::*;

  localparam int W  = 64;
  localparam int NI = 32;
  localparam int NO = 8;
  localparam int MW = 4;
  localparam int AW = 8;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       control;
  logic [AW-1:0]    address;
  logic [W-1:0]     data_in;
  logic [W-1:0]     data_out;
  logic             end_op, busy, error, core_rst_n, core_start;
  logic [MW-1:0]    core_mode;
  logic [NI*W-1:0]  core_in;
  logic             core_done, core_err;
  logic [NO*W-1:0]  core_out;

  crypto_host_itf #(
    .WIDTH(W), .N_IN(NI), .N_OUT(NO), .MODE_W(MW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .control    (control),
    .address    (address),
    .data_in    (data_in),
    .data_out   (data_out),
    .end_op     (end_op),
    .busy       (busy),
    .error      (error),
    .core_rst_n (core_rst_n),
    .core_start (core_start),
    .core_mode  (core_mode),
    .core_in    (core_in),
    .core_done  (core_done),
    .core_err   (core_err),
    .core_out   (core_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: m_age counts cycles since an accepted START
  // (-1 = not running, 1 = start-pulse cycle, >=2 = waiting on the core).
  logic [MW-1:0] m_mode;
  logic [W-1:0]  m_bank [NI];
  logic [W-1:0]  m_res  [NO];
  logic [W-1:0]  m_dout;
  logic          m_end, m_err, m_ill, m_crst;
  int            m_age;

  bit auto_core = 1'b0;
  int rem = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word(input int k);
    return core_in[k*W +: W];
  endfunction

  task automatic model_step();
    logic [W-1:0] rd;
    int a;
    a  = int'(address);
    rd = '0;
    if (a == 0) rd[3:0] = {m_ill, m_err, (m_age >= 1), m_end};
    else if (a <= NO) rd = m_res[a-1];
    if (!rst_n || control == CMD_SOFT_RST) begin
      m_mode = '0;
      for (int k = 0; k < NI; k++) m_bank[k] = '0;
      for (int k = 0; k < NO; k++) m_res[k] = '0;
      m_end = 0; m_err = 0; m_ill = 0; m_age = -1; m_crst = 0; m_dout = '0;
    end else begin
      m_dout = rd;
      m_crst = 1;
      if (m_age < 0) begin
        if (control == CMD_START) begin
          m_age = 1; m_end = 0; m_err = 0; m_ill = 0;
        end else if (control == CMD_WRITE) begin
          if (a == 0) m_mode = data_in[MW-1:0];
          else if (a <= NI) m_bank[a-1] = data_in;
        end
      end else begin
        if (control == CMD_WRITE || control == CMD_START) m_ill = 1;
        if (m_age == 1) m_age = 2;
        else if (core_err) begin
          m_err = 1; m_end = 1; m_age = -1;
        end else if (core_done) begin
          for (int k = 0; k < NO; k++) m_res[k] = core_out[k*W +: W];
          m_end = 1; m_age = -1;
        end else if (m_age - 2 == TO) begin
          m_err = 1; m_end = 1; m_age = -1;
        end else m_age++;
      end
    end
  endtask

  task automatic compare();
    int bad;
    bad = 0;
    check("data_out", data_out, m_dout);
    check("end_op", end_op, m_end);
    check("busy", busy, m_age >= 1);
    check("error", error, m_err);
    check("core_rst_n", core_rst_n, m_crst);
    check("core_start", core_start, m_age == 1);
    check("core_mode", core_mode, m_mode);
    for (int k = 0; k < NI; k++) begin
      if (word(k) !== m_bank[k]) begin
        bad = k;
        break;
      end
    end
    check($sformatf("core_in[%0d]", bad), word(bad), m_bank[bad]);
  endtask

  task automatic core_react();
    core_done = 1'b0;
    core_err  = 1'b0;
    if (core_start) rem = $urandom_range(0, 18);
    else if (rem == 0) begin
      core_err  = ($urandom_range(0, 5) == 0);
      core_done = core_err ? ($urandom_range(0, 1) == 1) : 1'b1;
      for (int k = 0; k < NO; k++) core_out[k*W +: W] = {$urandom, $urandom};
      rem = -1;
    end else if (rem > 0) rem--;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    if (auto_core) core_react();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    control = CMD_WRITE; address = a; data_in = d;
    tick();
    control = CMD_IDLE;
  endtask

  initial begin
    rst_n = 1'b0; control = CMD_IDLE; address = '0; data_in = '0;
    core_done = 1'b0; core_err = 1'b0; core_out = '0;

    // Reset and defaults
    tick();
    check("rst core_rst_n low", core_rst_n, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst end_op", end_op, 0);
    check("rst busy", busy, 0);
    check("rst error", error, 0);
    check("rst core_start", core_start, 0);
    check("rst core_mode", core_mode, 0);
    check("rst core_in0", word(0), 0);
    check("rst core_rst_n released", core_rst_n, 1);
    tick();
    check("rst status read", data_out, 0);

    // Load and start, core answers 10 cycles into BUSY
    wr(8'd0, 64'h4);
    check("mode loaded", core_mode, 4'b0100);
    wr(8'd1, 64'hfbc6216febc44546);
    wr(8'd25, 64'd48);
    check("core_in word0", word(0), 64'hfbc6216febc44546);
    check("core_in word24", word(24), 64'd48);
    control = CMD_START;
    tick();
    check("start pulse", core_start, 1);
    check("busy at t+1", busy, 1);
    control = CMD_IDLE;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("single start pulse", core_start, 0);
      check("no early end_op", end_op, 0);
    end
    core_out[63:0] = 64'h4d639518839d2300;
    core_done = 1'b1;
    tick();
    check("end_op at done+1", end_op, 1);
    check("busy drops at done+1", busy, 0);
    core_done = 1'b0;
    address = 8'd1;
    tick();
    check("result word0", data_out, 64'h4d639518839d2300);
    address = 8'd0;
    tick();
    check("status after op", data_out, 64'h1);

    // Busy protection
    control = CMD_START;
    tick();
    control = CMD_WRITE; address = 8'd1; data_in = 64'h1;
    tick();
    control = CMD_START;
    tick();
    control = CMD_IDLE; address = 8'd0;
    check("write dropped while busy", word(0), 64'hfbc6216febc44546);
    check("no second pulse", core_start, 0);
    core_out[63:0] = 64'h0123456789abcdef;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("busy op end_op", end_op, 1);
    tick();
    check("status ill_acc", data_out, 64'h9);

    // Error priority over done, followed by a back-to-back START
    control = CMD_START;
    tick();
    control = CMD_IDLE;
    tick();
    core_out[63:0] = 64'hdeadbeefdeadbeef;
    core_done = 1'b1; core_err = 1'b1;
    tick();
    check("err wins error", error, 1);
    check("err wins end_op", end_op, 1);
    core_done = 1'b0; core_err = 1'b0;
    address = 8'd1;
    tick();
    check("result kept on error", data_out, 64'h0123456789abcdef);
    control = CMD_START; address = 8'd0;
    tick();
    check("back-to-back start", core_start, 1);
    check("flags cleared on start", {end_op, error}, 2'b00);
    check("status error op", data_out, 64'h5);
    control = CMD_IDLE;
    tick();
    core_out[63:0] = 64'h55aa55aa55aa55aa;
    core_done = 1'b1;
    tick();
    check("min latency end_op", end_op, 1);
    check("min latency no error", error, 0);
    core_done = 1'b0;

    // Map bounds
    wr(8'(NI + 1), 64'hffff_ffff_ffff_ffff);
    check("oob write word0", word(0), 64'hfbc6216febc44546);
    check("oob write word31", word(31), 0);
    address = 8'(NO + 1);
    tick();
    tick();
    check("oob read", data_out, 0);
    address = 8'd0;

    // Watchdog then SOFT_RST
    control = CMD_START;
    tick();
    control = CMD_IDLE;
    tick();
    for (int i = 0; i < TO; i++) begin
      tick();
      check("no early timeout", error, 0);
      check("busy until timeout", busy, 1);
    end
    tick();
    check("timeout error", error, 1);
    check("timeout end_op", end_op, 1);
    check("timeout busy", busy, 0);
    control = CMD_SOFT_RST;
    tick();
    check("soft core_rst_n", core_rst_n, 0);
    check("soft end_op", end_op, 0);
    check("soft error", error, 0);
    check("soft mode", core_mode, 0);
    check("soft bank", word(0), 0);
    control = CMD_IDLE;
    tick();
    check("soft core_rst_n pulse", core_rst_n, 1);
    check("soft status", data_out, 0);

    // Randomized traffic with a responding core
    auto_core = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35)      control = CMD_WRITE;
      else if (r < 47) control = CMD_START;
      else if (r < 49) control = CMD_SOFT_RST;
      else if (r < 55) control = 4'($urandom_range(4, 15));
      else             control = CMD_IDLE;
      address = ($urandom_range(0, 30) == 0) ? 8'hff : 8'($urandom_range(0, NI + 6));
      data_in = {$urandom, $urandom};
      tick();
    end
    control = CMD_IDLE;
    for (int i = 0; i < 25; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
